// File: rtl/mmio_display_ctrl_if.sv
// mmio_display_ctrl_if: CPU data-bus bundle between the core and the MMIO display responder.
//   we/re        write/read strobes
//   addr         16-bit word address
//   wdata/rdata  16-bit write data from the CPU, registered read data back to it
interface mmio_display_ctrl_if;
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    modport master (output we, re, addr, wdata, input rdata);
    modport slave  (input we, re, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_display_ctrl.sv
// mmio_display_ctrl: MMIO responder driving HEX0..HEX5/LEDS from CPU stores and serving debounced SW.
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous reset, active-low
//   bus          CPU data bus (slave side), rdata registered
//   i_sw         raw asynchronous slide switches
//   o_leds       LED drive, active-high
//   o_hex0..5    7-segment drive, active-low, bit7 = DP
module mmio_display_ctrl #(
    parameter logic [15:0] BASE_ADDR       = 16'hFF00,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          BLINK_DIV       = 25000000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    mmio_display_ctrl_if.slave        bus,
    input  logic [9:0]                i_sw,
    output logic [9:0]                o_leds,
    output logic [7:0]                o_hex0,
    output logic [7:0]                o_hex1,
    output logic [7:0]                o_hex2,
    output logic [7:0]                o_hex3,
    output logic [7:0]                o_hex4,
    output logic [7:0]                o_hex5
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [BW-1:0] BL_MAX = BW'(BLINK_DIV - 1);
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0]   r_hexlo;
    logic [7:0]    r_hexhi;
    logic [9:0]    r_led;
    logic [7:0]    r_ctrl;
    logic [9:0]    r_sw_s1;
    logic [9:0]    r_sw_s2;
    logic [9:0]    r_sw_db;
    logic          r_chg;
    logic [DW-1:0] r_db_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [15:0]   r_rdata;
    logic [7:0]    r_hex [6];

    logic          w_hit;
    logic [3:0]    w_off;
    logic [15:0]   w_rd_val;
    logic          w_sync_chg;
    logic          w_accept;
    logic          w_blank;
    logic [23:0]   w_digits;

    always_comb begin
        w_hit      = bus.addr[15:4] == BASE_ADDR[15:4];
        w_off      = bus.addr[3:0];
        w_rd_val   = !w_hit        ? 16'h0 :
                     w_off == 4'd0 ? r_hexlo :
                     w_off == 4'd1 ? {8'h0, r_hexhi} :
                     w_off == 4'd2 ? {6'h0, r_led} :
                     w_off == 4'd3 ? {8'h0, r_ctrl} :
                     w_off == 4'd4 ? {r_chg, 5'h0, r_sw_db} : 16'h0;
        // A pending change in the synchroniser restarts the stability window, so it blocks acceptance.
        w_sync_chg = r_sw_s1 != r_sw_s2;
        w_accept   = !w_sync_chg && (r_sw_s2 != r_sw_db) && (r_db_cnt == DB_MAX);
        w_blank    = !r_ctrl[0] || (r_ctrl[1] && r_phase);
        w_digits   = {r_hexhi, r_hexlo};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hexlo     <= '0;
            r_hexhi     <= '0;
            r_led       <= '0;
            r_ctrl      <= 8'h01;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_sw_db     <= '0;
            r_chg       <= 1'b0;
            r_db_cnt    <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_rdata     <= '0;
            o_leds      <= '0;
            r_hex       <= '{default: 8'hFF};
        end else begin
            if (bus.we && w_hit && w_off == 4'd0) r_hexlo <= bus.wdata;
            if (bus.we && w_hit && w_off == 4'd1) r_hexhi <= bus.wdata[7:0];
            if (bus.we && w_hit && w_off == 4'd2) r_led   <= bus.wdata[9:0];
            if (bus.we && w_hit && w_off == 4'd3) r_ctrl  <= bus.wdata[7:0];
            if (bus.re) r_rdata <= w_rd_val;
            r_sw_s1  <= i_sw;
            r_sw_s2  <= r_sw_s1;
            r_db_cnt <= (w_sync_chg || w_accept) ? '0 :
                        (r_sw_s2 != r_sw_db)     ? r_db_cnt + 1'b1 : r_db_cnt;
            if (w_accept) r_sw_db <= r_sw_s2;
            // Acceptance outranks the read-clear so a change arriving on the read edge is not lost.
            r_chg <= w_accept || (r_chg && !(bus.re && w_hit && w_off == 4'd4));
            r_blink_cnt <= (r_blink_cnt == BL_MAX) ? '0 : r_blink_cnt + 1'b1;
            if (r_blink_cnt == BL_MAX) r_phase <= !r_phase;
            o_leds <= r_led;
            for (int i = 0; i < 6; i++)
                r_hex[i] <= w_blank ? 8'hFF : {~r_ctrl[2+i], SEG[w_digits[4*i +: 4]]};
        end
    end

    assign bus.rdata = r_rdata;
    assign o_hex0    = r_hex[0];
    assign o_hex1    = r_hex[1];
    assign o_hex2    = r_hex[2];
    assign o_hex3    = r_hex[3];
    assign o_hex4    = r_hex[4];
    assign o_hex5    = r_hex[5];
endmodule

// File: tb/tb_mmio_display_ctrl.sv
// tb_mmio_display_ctrl: directed table, corner sequences and random traffic against a behavioural model.
module tb_mmio_display_ctrl;
    localparam int DEB = 4;
    localparam int BLK = 8;
    localparam logic [47:0] HX0 = {6{8'hC0}};
    localparam logic [47:0] HX1 = 48'hC0C0_8386_868E;
    localparam logic [47:0] HX2 = 48'hA488_8386_868E;
    localparam logic [47:0] HFF = {6{8'hFF}};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw = '0;
    logic [9:0] leds;
    logic [7:0] h0, h1, h2, h3, h4, h5;
    int checks = 0;
    int failures = 0;

    mmio_display_ctrl_if bus();

    mmio_display_ctrl #(.BASE_ADDR(16'hFF00), .DEBOUNCE_CYCLES(DEB), .BLINK_DIV(BLK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_sw(sw), .o_leds(leds),
        .o_hex0(h0), .o_hex1(h1), .o_hex2(h2), .o_hex3(h3), .o_hex4(h4), .o_hex5(h5)
    );

    always #5 clk = ~clk;

    // Behavioural reference: registers as plain values, blink phase from edges elapsed since reset,
    // debounce from the length of the current stable run of the synchronised switches.
    logic [6:0]  segs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] m_hexlo, m_rdata;
    logic [7:0]  m_hexhi, m_ctrl;
    logic [9:0]  m_led, m_db, m_s1, m_s2, m_leds;
    logic        m_chg;
    logic [47:0] m_hex;
    int          m_stable, m_edges;

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a[15:4] != 12'hFF0) return 16'h0;
        case (a[3:0])
            4'd0: return m_hexlo;
            4'd1: return {8'h0, m_hexhi};
            4'd2: return {6'h0, m_led};
            4'd3: return {8'h0, m_ctrl};
            4'd4: return {m_chg, 5'h0, m_db};
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [47:0] m_disp();
        logic [47:0] v;
        logic [23:0] d;
        logic        phase;
        phase = ((m_edges / BLK) % 2) == 1;
        if (!m_ctrl[0] || (m_ctrl[1] && phase)) return HFF;
        d = {m_hexhi, m_hexlo};
        for (int i = 0; i < 6; i++) v[8*i +: 8] = {~m_ctrl[2+i], segs[d[4*i +: 4]]};
        return v;
    endfunction

    task automatic model_edge();
        logic hit, acc;
        if (!rst_n) begin
            m_hexlo = '0; m_hexhi = '0; m_led = '0; m_ctrl = 8'h01; m_db = '0; m_chg = 1'b0;
            m_s1 = '0; m_s2 = '0; m_stable = 0; m_edges = 0; m_rdata = '0; m_leds = '0; m_hex = HFF;
        end else begin
            hit = bus.addr[15:4] == 12'hFF0;
            m_hex  = m_disp();
            m_leds = m_led;
            if (bus.re) m_rdata = m_read(bus.addr);
            if (bus.we && hit && bus.addr[3:0] == 4'd0) m_hexlo = bus.wdata;
            if (bus.we && hit && bus.addr[3:0] == 4'd1) m_hexhi = bus.wdata[7:0];
            if (bus.we && hit && bus.addr[3:0] == 4'd2) m_led = bus.wdata[9:0];
            if (bus.we && hit && bus.addr[3:0] == 4'd3) m_ctrl = bus.wdata[7:0];
            acc = (m_s1 == m_s2) && (m_s2 != m_db) && (m_stable == DEB);
            if (bus.re && hit && bus.addr[3:0] == 4'd4) m_chg = 1'b0;
            if (acc) begin m_chg = 1'b1; m_db = m_s2; end
            m_stable = (m_s1 != m_s2) ? 0 : (m_stable < 1000 ? m_stable + 1 : m_stable);
            m_s2 = m_s1;
            m_s1 = sw;
            m_edges++;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [15:0] a, input logic [15:0] d);
        bus.we = we; bus.re = re; bus.addr = a; bus.wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_rdata", 64'(bus.rdata), 64'(m_rdata));
        check("model_leds", 64'(leds), 64'(m_leds));
        check("model_hex", 64'({h5, h4, h3, h2, h1, h0}), 64'(m_hex));
    endtask

    function automatic logic [47:0] hexv();
        return {h5, h4, h3, h2, h1, h0};
    endfunction

    typedef struct {
        logic        we, re;
        logic [15:0] addr, wdata, rdata;
        logic [9:0]  leds;
        logic [47:0] hex;
    } vec_t;
    vec_t tbl [14];

    initial begin
        int blanks, dps, led_bad;
        tbl[0]  = '{1'b1, 1'b0, 16'hFF00, 16'hBEEF, 16'h0000, 10'h000, HX0};
        tbl[1]  = '{1'b1, 1'b0, 16'hFF01, 16'h002A, 16'h0000, 10'h000, HX1};
        tbl[2]  = '{1'b1, 1'b0, 16'hFF02, 16'h0155, 16'h0000, 10'h000, HX2};
        tbl[3]  = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'hBEEF, 10'h155, HX2};
        tbl[4]  = '{1'b0, 1'b1, 16'hFF01, 16'h0000, 16'h002A, 10'h155, HX2};
        tbl[5]  = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0155, 10'h155, HX2};
        tbl[6]  = '{1'b0, 1'b1, 16'hFF03, 16'h0000, 16'h0001, 10'h155, HX2};
        tbl[7]  = '{1'b0, 1'b1, 16'hFF07, 16'h0000, 16'h0000, 10'h155, HX2};
        tbl[8]  = '{1'b1, 1'b1, 16'hFF07, 16'hFFFF, 16'h0000, 10'h155, HX2};
        tbl[9]  = '{1'b1, 1'b0, 16'hFE00, 16'h1234, 16'h0000, 10'h155, HX2};
        tbl[10] = '{1'b1, 1'b1, 16'hFF02, 16'h0AAA, 16'h0155, 10'h155, HX2};
        tbl[11] = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h02AA, 10'h2AA, HX2};
        tbl[12] = '{1'b0, 1'b1, 16'hFE04, 16'h0000, 16'h0000, 10'h2AA, HX2};
        tbl[13] = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'hBEEF, 10'h2AA, HX2};
        drive(0, 0, 16'h0, 16'h0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hex", 64'(hexv()), 64'(HFF));
        end
        check("rst_leds", 64'(leds), 64'h0);
        check("rst_rdata", 64'(bus.rdata), 64'h0);
        rst_n = 1'b1;
        tick();
        check("release_hex", 64'(hexv()), 64'(HX0));

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
            tick();
            check($sformatf("tbl%0d_rdata", i), 64'(bus.rdata), 64'(tbl[i].rdata));
            check($sformatf("tbl%0d_leds", i), 64'(leds), 64'(tbl[i].leds));
            check($sformatf("tbl%0d_hex", i), 64'(hexv()), 64'(tbl[i].hex));
        end
        drive(0, 0, 16'h0, 16'h0);

        // Bounced step to 3FF: acceptance lands on the 7th edge after the final step.
        sw = 10'h3FF; tick();
        sw = 10'h000; tick();
        sw = 10'h3FF;
        for (int i = 0; i < 6; i++) tick();
        drive(0, 1, 16'hFF04, 16'h0); tick();
        check("deb_before", 64'(bus.rdata), 64'h0000);
        tick();
        check("deb_accept", 64'(bus.rdata), 64'h83FF);
        tick();
        check("deb_cleared", 64'(bus.rdata), 64'h03FF);
        drive(0, 0, 16'h0, 16'h0);

        // Leave chg set, then collide a new acceptance with an SWREG read.
        sw = 10'h000;
        for (int i = 0; i < 7; i++) tick();
        sw = 10'h3FF;
        for (int i = 0; i < 6; i++) tick();
        drive(0, 1, 16'hFF04, 16'h0); tick();
        check("collide_old", 64'(bus.rdata), 64'h8000);
        tick();
        check("collide_set_wins", 64'(bus.rdata), 64'h83FF);
        tick();
        check("collide_cleared", 64'(bus.rdata), 64'h03FF);
        drive(0, 0, 16'h0, 16'h0);

        // Blink with DP0 lit: any 32 consecutive edges split evenly between digits and blank.
        drive(1, 0, 16'hFF03, 16'h0007); tick();
        drive(0, 0, 16'h0, 16'h0); tick();
        blanks = 0; dps = 0; led_bad = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (hexv() === HFF) blanks++;
            if (h0 === 8'h0E) dps++;
            if (leds !== 10'h2AA) led_bad++;
        end
        check("blink_blank_cnt", 64'(blanks), 64'd16);
        check("blink_dp0_cnt", 64'(dps), 64'd16);
        check("blink_leds_steady", 64'(led_bad), 64'd0);

        // Reset in the middle of a debounce window.
        sw = 10'h000;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0; tick();
        check("midrst_hex", 64'(hexv()), 64'(HFF));
        check("midrst_rdata", 64'(bus.rdata), 64'h0);
        rst_n = 1'b1; tick();
        check("midrst_release_hex", 64'(hexv()), 64'(HX0));
        check("midrst_leds", 64'(leds), 64'h0);
        drive(0, 1, 16'hFF04, 16'h0); tick();
        check("midrst_swreg", 64'(bus.rdata), 64'h0);
        drive(0, 1, 16'hFF03, 16'h0); tick();
        check("midrst_ctrl", 64'(bus.rdata), 64'h0001);
        drive(0, 0, 16'h0, 16'h0);

        for (int i = 0; i < 1500; i++) begin
            rst_n = $urandom_range(0, 299) != 0;
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 85 ? {12'hFF0, 4'($urandom_range(0, 7))} : 16'($urandom),
                  16'($urandom));
            if ($urandom_range(0, 99) < 4) sw = 10'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
